// File: rtl/hvac_thermostat_fsm.sv
// ============================================================================
// hvac_thermostat_fsm
//
// Thermostat controller between the sensor comparator bank and the relay
// drivers. The temperature arrives as a thermometer code. The controller
// debounces the code into a filtered level and drives the heat, fan and ac
// relays from a Moore FSM. It provides threshold hysteresis, a minimum-on
// dwell, compressor anti-short-cycle lockout, fan run-on, and a sticky fault
// when a malformed code is held.
//
// Ports
//   clk         in   1           system clock, rising edge
//   reset       in   1           synchronous, active-high
//   temp_therm  in   NUM_LEVELS  bit i set => temp >= threshold i (bit 0 lowest)
//   mode        in   2           00 OFF, 01 HEAT, 10 COOL, 11 AUTO
//   heat        out  1           heater relay
//   fan         out  1           fan relay
//   ac          out  1           compressor relay
//   lockout     out  1           compressor lockout counter is non-zero
//   fault       out  1           sticky malformed-input flag
//   state_o     out  3           0 IDLE, 1 HEATING, 2 COOLING, 3 RUNON, 4 FAULT
// ============================================================================
module hvac_thermostat_fsm #(
    parameter int NUM_LEVELS   = 5,
    parameter int HEAT_ON_LVL  = 0,
    parameter int HEAT_OFF_LVL = 2,
    parameter int COOL_OFF_LVL = 3,
    parameter int COOL_ON_LVL  = 5,
    parameter int DEBOUNCE_CYC = 3,
    parameter int MIN_ON_CYC   = 8,
    parameter int MIN_OFF_CYC  = 16,
    parameter int RUNON_CYC    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_LEVELS-1:0] temp_therm,
    input  logic [1:0]            mode,
    output logic                  heat,
    output logic                  fan,
    output logic                  ac,
    output logic                  lockout,
    output logic                  fault,
    output logic [2:0]            state_o
);

    localparam int LVL_W     = $clog2(NUM_LEVELS + 1);
    localparam int DB_W      = $clog2(DEBOUNCE_CYC + 1);
    localparam int DWELL_W   = (MIN_ON_CYC > 1)  ? $clog2(MIN_ON_CYC)      : 1;
    localparam int LOCK_W    = (MIN_OFF_CYC > 0) ? $clog2(MIN_OFF_CYC + 1) : 1;
    localparam int RUNON_W   = (RUNON_CYC > 0)   ? $clog2(RUNON_CYC + 1)   : 1;

    localparam logic [LVL_W-1:0]   HEAT_ON_L   = LVL_W'(HEAT_ON_LVL);
    localparam logic [LVL_W-1:0]   HEAT_OFF_L  = LVL_W'(HEAT_OFF_LVL);
    localparam logic [LVL_W-1:0]   COOL_OFF_L  = LVL_W'(COOL_OFF_LVL);
    localparam logic [LVL_W-1:0]   COOL_ON_L   = LVL_W'(COOL_ON_LVL);
    localparam logic [DB_W-1:0]    DB_MAX      = DB_W'(DEBOUNCE_CYC);
    localparam logic [DWELL_W-1:0] DWELL_LAST  = DWELL_W'(MIN_ON_CYC - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LOAD   = LOCK_W'(MIN_OFF_CYC);
    localparam logic [RUNON_W-1:0] RUNON_LAST  = RUNON_W'((RUNON_CYC > 0) ? RUNON_CYC - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEATING = 3'd1,
        ST_COOLING = 3'd2,
        ST_RUNON   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    // With no run-on configured, a heat/cool exit lands directly in IDLE.
    localparam state_t EXIT_ST = (RUNON_CYC == 0) ? ST_IDLE : ST_RUNON;

    state_t                  r_state;
    state_t                  w_next;
    logic [NUM_LEVELS-1:0]   r_prev_code;
    logic [DB_W-1:0]         r_db_cnt;
    logic [LVL_W-1:0]        r_filt_lvl;
    logic                    r_filt_valid;
    logic [DWELL_W-1:0]      r_dwell;
    logic [LOCK_W-1:0]       r_lock_cnt;
    logic [RUNON_W-1:0]      r_runon_cnt;

    logic                    w_code_valid;
    logic [LVL_W-1:0]        w_raw_lvl;
    logic [DB_W-1:0]         w_db_next;
    logic                    w_db_done;
    logic                    w_filt_load;
    logic                    w_fault_trig;
    logic                    w_heat_dem;
    logic                    w_cool_dem;
    logic                    w_dwell_done;

    // ------------------------------------------------------------------------
    // Code check and level extraction
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_code_valid = 1'b1;
        w_raw_lvl    = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            w_raw_lvl = w_raw_lvl + LVL_W'(temp_therm[i]);
        end
        // A set bit above a clear bit cannot come from a comparator bank.
        for (int i = 1; i < NUM_LEVELS; i++) begin
            if (temp_therm[i] && !temp_therm[i-1]) begin
                w_code_valid = 1'b0;
            end
        end
    end

    // Run length of the current code, including this edge; saturates so a
    // long-held code keeps w_db_done asserted without wrapping.
    always_comb begin
        if (temp_therm != r_prev_code) begin
            w_db_next = DB_W'(1);
        end else if (r_db_cnt == DB_MAX) begin
            w_db_next = r_db_cnt;
        end else begin
            w_db_next = r_db_cnt + DB_W'(1);
        end
    end

    assign w_db_done    = (w_db_next == DB_MAX);
    assign w_filt_load  = w_db_done &  w_code_valid;
    assign w_fault_trig = w_db_done & ~w_code_valid;

    assign w_heat_dem   = r_filt_valid & mode[0] & (r_filt_lvl <= HEAT_ON_L);
    assign w_cool_dem   = r_filt_valid & mode[1] & (r_filt_lvl >= COOL_ON_L)
                        & (r_lock_cnt == '0);
    assign w_dwell_done = (r_dwell >= DWELL_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (w_fault_trig) begin
            w_next = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_heat_dem)      w_next = ST_HEATING;
                    else if (w_cool_dem) w_next = ST_COOLING;
                end
                ST_HEATING: begin
                    // OFF overrides the dwell; a threshold exit honours it.
                    if (mode == 2'b00) begin
                        w_next = EXIT_ST;
                    end else if (w_dwell_done && (r_filt_lvl >= HEAT_OFF_L || !mode[0])) begin
                        w_next = EXIT_ST;
                    end
                end
                ST_COOLING: begin
                    if (mode == 2'b00) begin
                        w_next = EXIT_ST;
                    end else if (w_dwell_done && (r_filt_lvl <= COOL_OFF_L || !mode[1])) begin
                        w_next = EXIT_ST;
                    end
                end
                ST_RUNON: begin
                    if (w_heat_dem)                      w_next = ST_HEATING;
                    else if (w_cool_dem)                 w_next = ST_COOLING;
                    else if (r_runon_cnt == RUNON_LAST)  w_next = ST_IDLE;
                end
                ST_FAULT: w_next = ST_FAULT;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_prev_code  <= '0;
            r_db_cnt     <= '0;
            r_filt_lvl   <= '0;
            r_filt_valid <= 1'b0;
            r_dwell      <= '0;
            r_lock_cnt   <= '0;
            r_runon_cnt  <= '0;
        end else begin
            r_state     <= w_next;
            r_prev_code <= temp_therm;
            r_db_cnt    <= w_db_next;

            if (w_filt_load) begin
                r_filt_lvl   <= w_raw_lvl;
                r_filt_valid <= 1'b1;
            end

            if (w_next != r_state) begin
                r_dwell <= '0;
            end else if ((r_state == ST_HEATING || r_state == ST_COOLING) &&
                         r_dwell != DWELL_LAST) begin
                r_dwell <= r_dwell + DWELL_W'(1);
            end

            if (w_next != r_state) begin
                r_runon_cnt <= '0;
            end else if (r_state == ST_RUNON && r_runon_cnt != RUNON_LAST) begin
                r_runon_cnt <= r_runon_cnt + RUNON_W'(1);
            end

            // Any departure from COOLING arms the compressor rest period.
            if (r_state == ST_COOLING && w_next != ST_COOLING) begin
                r_lock_cnt <= LOCK_LOAD;
            end else if (r_lock_cnt != '0) begin
                r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode from the state register only
    // ------------------------------------------------------------------------
    always_comb begin
        heat  = 1'b0;
        fan   = 1'b0;
        ac    = 1'b0;
        fault = 1'b0;
        case (r_state)
            ST_HEATING: begin heat = 1'b1; fan = 1'b1; end
            ST_COOLING: begin ac   = 1'b1; fan = 1'b1; end
            ST_RUNON:   fan   = 1'b1;
            ST_FAULT:   fault = 1'b1;
            default:    ;
        endcase
    end

    assign lockout = (r_lock_cnt != '0);
    assign state_o = r_state;

endmodule

// File: tb/tb_hvac_thermostat_fsm.sv
// ============================================================================
// tb_hvac_thermostat_fsm
//
// Directed bench for hvac_thermostat_fsm at default parameters. Outputs are
// packed as {heat, fan, ac, lockout, fault, state_o[2:0]} and compared with
// hand-computed vectors one nanosecond after each rising edge.
// ============================================================================
module tb_hvac_thermostat_fsm;

    logic       clk;
    logic       reset;
    logic [4:0] temp_therm;
    logic [1:0] mode;
    logic       heat;
    logic       fan;
    logic       ac;
    logic       lockout;
    logic       fault;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HEAT = 3'd1;
    localparam logic [2:0] S_COOL = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    hvac_thermostat_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .temp_therm (temp_therm),
        .mode       (mode),
        .heat       (heat),
        .fan        (fan),
        .ac         (ac),
        .lockout    (lockout),
        .fault      (fault),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got h=%0b f=%0b a=%0b l=%0b flt=%0b st=%0d, expected h=%0b f=%0b a=%0b l=%0b flt=%0b st=%0d",
                     tag, got[7], got[6], got[5], got[4], got[3], got[2:0],
                     exp[7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    function automatic logic [7:0] outs();
        return {heat, fan, ac, lockout, fault, state_o};
    endfunction

    function automatic logic [7:0] ex(input logic h, input logic f, input logic a,
                                       input logic l, input logic flt, input logic [2:0] st);
        return {h, f, a, l, flt, st};
    endfunction

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, check the reset state, then release it with
    // the given inputs already applied.
    task automatic do_reset(input string tag, input logic [4:0] code, input logic [1:0] md);
        reset = 1'b1;
        tick(2);
        check(tag, outs(), ex(0, 0, 0, 0, 0, S_IDLE));
        temp_therm = code;
        mode       = md;
        reset      = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        temp_therm = 5'b00000;
        mode       = 2'b00;

        // ---- 1: cold start in AUTO heats on the 4th edge --------------------
        do_reset("t1_reset", 5'b00000, 2'b11);
        tick(3);
        check("t1_edge3_idle", outs(), ex(0, 0, 0, 0, 0, S_IDLE));
        tick(1);
        check("t1_edge4_heat", outs(), ex(1, 1, 0, 0, 0, S_HEAT));

        // ---- 2: satisfied at dwell 2, dwell honoured, 4-edge run-on ---------
        tick(2);                        // dwell = 2
        temp_therm = 5'b00011;          // level 2 reaches HEAT_OFF
        tick(4);                        // dwell = 6, filtered level already 2
        check("t2_dwell6_heat", outs(), ex(1, 1, 0, 0, 0, S_HEAT));
        tick(1);                        // dwell = 7
        check("t2_dwell7_heat", outs(), ex(1, 1, 0, 0, 0, S_HEAT));
        tick(1);
        check("t2_runon1", outs(), ex(0, 1, 0, 0, 0, S_RUN));
        tick(3);
        check("t2_runon4", outs(), ex(0, 1, 0, 0, 0, S_RUN));
        tick(1);
        check("t2_idle", outs(), ex(0, 0, 0, 0, 0, S_IDLE));

        // ---- 4: short invalid glitch ignored, held invalid faults ----------
        temp_therm = 5'b00101;          // invalid for a single edge
        tick(1);
        temp_therm = 5'b00011;
        tick(4);
        check("t4_glitch_nofault", outs(), ex(0, 0, 0, 0, 0, S_IDLE));
        temp_therm = 5'b00101;
        tick(2);
        check("t4_invalid2_nofault", outs(), ex(0, 0, 0, 0, 0, S_IDLE));
        tick(1);
        check("t4_invalid3_fault", outs(), ex(0, 0, 0, 0, 1, S_FLT));
        temp_therm = 5'b00000;          // strong heat demand must not revive it
        tick(8);
        check("t4_fault_sticky", outs(), ex(0, 0, 0, 0, 1, S_FLT));

        // ---- 3: cooling exit arms 16-edge compressor lockout ---------------
        do_reset("t3_reset", 5'b11111, 2'b11);
        tick(4);
        check("t3_cooling", outs(), ex(0, 1, 1, 0, 0, S_COOL));
        tick(7);                        // dwell = 7
        temp_therm = 5'b00111;          // level 3 satisfies cooling
        tick(3);
        check("t3_before_exit", outs(), ex(0, 1, 1, 0, 0, S_COOL));
        tick(1);                        // exit edge X, lockout loaded with 16
        check("t3_exit_runon_lock", outs(), ex(0, 1, 0, 1, 0, S_RUN));
        temp_therm = 5'b11111;          // cooling demand returns immediately
        tick(4);                        // X+4: run-on done, still locked out
        check("t3_idle_locked", outs(), ex(0, 0, 0, 1, 0, S_IDLE));
        tick(11);                       // X+15: counter = 1
        check("t3_lock_last", outs(), ex(0, 0, 0, 1, 0, S_IDLE));
        tick(1);                        // X+16: counter = 0
        check("t3_lock_clear", outs(), ex(0, 0, 0, 0, 0, S_IDLE));
        tick(1);
        check("t3_cool_again", outs(), ex(0, 1, 1, 0, 0, S_COOL));

        // ---- 5: mode OFF bypasses dwell, COOL mode never heats -------------
        do_reset("t5_reset", 5'b00000, 2'b11);
        tick(4);
        check("t5_heating", outs(), ex(1, 1, 0, 0, 0, S_HEAT));
        tick(1);                        // dwell = 1
        mode = 2'b00;
        tick(1);
        check("t5_off_runon", outs(), ex(0, 1, 0, 0, 0, S_RUN));
        mode = 2'b10;
        tick(4);
        check("t5_cool_mode_idle", outs(), ex(0, 0, 0, 0, 0, S_IDLE));
        tick(8);
        check("t5_cool_mode_no_heat", outs(), ex(0, 0, 0, 0, 0, S_IDLE));
        mode = 2'b11;
        tick(1);
        check("t5_auto_heats", outs(), ex(1, 1, 0, 0, 0, S_HEAT));

        // ---- 6: reset during cooling drops every relay next edge -----------
        do_reset("t6_reset", 5'b11111, 2'b11);
        tick(4);
        tick(2);
        check("t6_cooling", outs(), ex(0, 1, 1, 0, 0, S_COOL));
        reset = 1'b1;
        tick(1);
        check("t6_reset_mid_cool", outs(), ex(0, 0, 0, 0, 0, S_IDLE));
        reset = 1'b0;
        tick(4);
        check("t6_recool_no_lock", outs(), ex(0, 1, 1, 0, 0, S_COOL));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
